// File: rtl/fetch_ctrl.sv
`timescale 1ns/1ps
// fetch_ctrl: instruction fetch sequencer.
// Walks a program counter through an instruction cache. Each fetch takes one
// capture cycle (FETCH), then presents the cached word to decode (VALID) until
// decode accepts it. Branches and flushes redirect the PC. A halt opcode parks
// the sequencer in HALT until the next start.
//
// Parameters
//   RESET_PC   PC loaded on reset and on start
//   HLT_OP     opcode in ir[15:11] that halts fetch
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin fetching from RESET_PC (IDLE or HALT only)
//   pc_addr    fetch address to the instruction cache
//   ic_en      instruction cache capture enable (one cycle per fetch)
//   ir         registered instruction word from the cache
//   ir_valid   ir holds the instruction at pc_addr for decode
//   ir_ready   decode acceptance
//   br_taken   branch taken, only meaningful on acceptance
//   br_target  redirect address for br_taken and flush
//   flush      redirect to br_target from FETCH or VALID
//   halted     HALT state active
//   fetch_cnt  accepted instruction count, saturating
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [4:0]  HLT_OP   = 5'b11111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] pc_addr,
    output logic        ic_en,
    input  logic [15:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        flush,
    output logic        halted,
    output logic [15:0] fetch_cnt
);

    typedef enum logic [1:0] {IDLE, FETCH, VALID, HALT} state_t;

    state_t state;
    logic   is_halt_op;

    always_comb begin
        is_halt_op = (ir[15:11] == HLT_OP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc_addr   <= RESET_PC;
            ic_en     <= 1'b0;
            ir_valid  <= 1'b0;
            halted    <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    // flush is ignored here; only start leaves these states
                    if (start) begin
                        state     <= FETCH;
                        pc_addr   <= RESET_PC;
                        ic_en     <= 1'b1;
                        halted    <= 1'b0;
                        fetch_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (flush) begin
                        // re-issue the capture at the new address
                        pc_addr <= br_target;
                        ic_en   <= 1'b1;
                    end else begin
                        ic_en    <= 1'b0;
                        ir_valid <= 1'b1;
                        state    <= VALID;
                    end
                end
                VALID: begin
                    if (flush) begin
                        // flush wins over a simultaneous acceptance, which is not counted
                        pc_addr  <= br_target;
                        ir_valid <= 1'b0;
                        ic_en    <= 1'b1;
                        state    <= FETCH;
                    end else if (ir_ready) begin
                        ir_valid <= 1'b0;
                        if (fetch_cnt != '1) begin
                            fetch_cnt <= fetch_cnt + 16'd1;
                        end
                        if (is_halt_op) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            pc_addr <= br_taken ? br_target : pc_addr + 16'd1;
                            ic_en   <= 1'b1;
                            state   <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
